// File: rtl/sar_search_if.sv
// Bus between the SAR search controller and its comparator/requester side.
// The master modport is the controller; the slave modport is the environment.
interface sar_search_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic             cmp_gt;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    input  start, abort, cmp_gt,
    output trial, busy, done, result
  );

  modport slave (
    output start, abort, cmp_gt,
    input  trial, busy, done, result
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search controller: resolves one bit per clock, MSB first,
// using an external comparator's greater-than bit to converge on the unknown target.
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  sar_search_if.master  bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] resolved;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      trial_q  <= '0;
      idx_q    <= IDX_MSB;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_d;
      trial_q  <= trial_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.start && !bus.abort) state_d = SEARCH;
      SEARCH: begin
        if (bus.abort)          state_d = IDLE;
        else if (idx_q == '0)   state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The bit under test is kept only if the comparator says the trial is not above the target.
  always_comb begin
    resolved = trial_q;
    if (bus.cmp_gt) resolved[idx_q] = 1'b0;

    trial_d  = trial_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state)
      IDLE: begin
        trial_d = '0;
        busy_d  = 1'b0;
        idx_d   = IDX_MSB;
        if (bus.start && !bus.abort) begin
          trial_d = MSB_ONE;
          busy_d  = 1'b1;
        end
      end
      SEARCH: begin
        if (bus.abort) begin
          trial_d = '0;
          busy_d  = 1'b0;
          idx_d   = IDX_MSB;
        end else if (idx_q == '0) begin
          trial_d  = resolved;
          result_d = resolved;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          idx_d    = IDX_MSB;
        end else begin
          trial_d = resolved | (ONE << (idx_q - IDX_W'(1)));
          idx_d   = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        trial_d = '0;
        busy_d  = 1'b0;
        idx_d   = IDX_MSB;
      end
      default: begin
        trial_d = '0;
        busy_d  = 1'b0;
        idx_d   = IDX_MSB;
      end
    endcase
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search controller: the initiating side of a magnitude comparator.
- Drives a trial word to an external combinational comparator and reads back that comparator's single "greater-than" bit.
- Resolves one bit per clock, MSB first, and converges on an unknown target value held on the comparator's other input.
- Used wherever a digital value must be recovered through a comparator-only interface (SAR ADC-style loops, threshold discovery).

Parameters:
- WIDTH, 8, width of trial/result words and number of bits resolved (>= 2).

Ports:
- clk     input   1      rising-edge clock
- rst_n   input   1      asynchronous active-low reset
- start   input   1      request a new search; honoured only in IDLE
- abort   input   1      synchronous cancel of a search in progress
- cmp_gt  input   1      external comparator output, 1 when trial > target (combinational on trial)
- trial   output  WIDTH  current trial word driven to comparator
- busy    output  1      high while searching
- done    output  1      one-cycle pulse, result valid
- result  output  WIDTH  last completed search value; held until next completion

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (any time, including mid-search):
  - state=IDLE; trial=0, busy=0, done=0, result=0.
  - Internal bit index = WIDTH-1.
  - Takes effect immediately on assertion; no done is produced for an interrupted search.
- All outputs are registered.
- State IDLE:
  - trial=0, busy=0, done=0.
  - start=1 and abort=0 at an edge → SEARCH; trial <= 1<<(WIDTH-1), index <= WIDTH-1, busy <= 1.
  - start=1 with abort=1 → remain IDLE.
- State SEARCH, at each edge with abort=0, for current index i:
  - Resolved word v = trial with bit i cleared if cmp_gt=1, else trial unchanged.
  - If i>0: trial <= v | (1<<(i-1)); index <= i-1.
  - If i==0: result <= v; trial <= v; state → DONE; done <= 1; busy <= 0.
  - cmp_gt is sampled only at these edges; its value in other states is ignored.
- SEARCH with abort=1 at an edge:
  - → IDLE; trial <= 0, busy <= 0.
  - result unchanged; no done pulse.
- State DONE (exactly one cycle):
  - done=1, busy=0, trial=final value.
  - Next edge → IDLE; done <= 0, trial <= 0.
  - start or abort during DONE is ignored.
- start while busy (SEARCH) is ignored; the search continues undisturbed.
- Latency: done is high in the cycle following the WIDTH-th edge after the edge that accepted start. Back-to-back searches are therefore spaced by at least WIDTH+2 cycles.
- Arithmetic: unsigned; the result equals the largest v with v <= target.
  - Target 0 yields 0.
  - Target 2^WIDTH-1 yields all ones.
  - No wrap-around is possible.
- Index counter width: $clog2(WIDTH).

Test Plan:
- Bench wiring: the bench comparator model drives cmp_gt = (trial > target) combinationally.
- WIDTH=8, target=0xA5, pulse start:
  - trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
  - done high for exactly one cycle, 8 edges after the start edge.
  - result=0xA5; busy high for exactly 8 cycles.
- target=0x00 → result 0x00; target=0xFF → result 0xFF; target=0x80 → result 0x80.
  - In each case, done pulses once and trial returns to 0 the cycle after done.
- Start target=0x3C; re-pulse start at the 3rd search cycle:
  - Second start is ignored; trial sequence is unaffected.
  - result=0x3C; exactly one done pulse.
- Complete a search with target=0x11, then start a search with target=0x77 and assert abort at the 4th search cycle:
  - Next cycle busy=0, trial=0, no done, result stays 0x11.
  - A subsequent start with target=0x77 yields 0x77.
- Drop rst_n asynchronously (between clock edges) mid-search:
  - Outputs go to 0/IDLE immediately.
  - After release, start with target=0x5A → result 0x5A.
  - start asserted together with abort in IDLE → no search begins (busy stays 0).
